// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command/response bytes and parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;
    localparam logic [7:0] PS2_RSP_RESEND   = 8'hFE;

    localparam logic [3:0] PS2_EDGE_PARITY = 4'd9;
    localparam logic [3:0] PS2_EDGE_STOP   = 4'd10;
    localparam logic [3:0] PS2_EDGE_ACK    = 4'd11;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer with falling-edge detect for one open-drain PS/2 line.
module ps2_line_sync (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic line_in,
    output logic level,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = line_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Idle bus is pulled high, so reset to 1 to avoid a false edge on release.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q;
    assign fall  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-edge shift, ack/nack/timeout report.
// Define PS2_TX_ACK_CHECK_EN to turn a high data line on edge 11 into an error.
//
// state      | meaning
// IDLE       | bus released, waiting for tx_valid
// INHIBIT    | clock held low for the inhibit period
// RELEASE    | clock released, start bit on data, watchdog armed
// SHIFT      | data driven on device clock falling edges 1..10, ack sampled on 11
// WAIT_IDLE  | waiting for both lines high before reporting
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 50_000_000,
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750_000
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

`ifdef PS2_TX_ACK_CHECK_EN
    localparam bit ACK_CHECK = 1'b1;
`else
    localparam bit ACK_CHECK = 1'b0;
`endif

    // A zero cycle count falls back to the standard 100 us / 15 ms derived from CLK_HZ.
    localparam int unsigned INHIBIT_EFF = (INHIBIT_CYCLES != 0) ? INHIBIT_CYCLES : (CLK_HZ / 10_000);
    localparam int unsigned TIMEOUT_EFF = (TIMEOUT_CYCLES != 0) ? TIMEOUT_CYCLES : ((CLK_HZ / 1000) * 15);
    localparam int unsigned TMR_MAX     = (INHIBIT_EFF > TIMEOUT_EFF) ? INHIBIT_EFF : TIMEOUT_EFF;
    localparam int unsigned TMR_W       = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] INHIBIT_LOAD = TMR_W'(INHIBIT_EFF - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_EFF - 1);
    localparam logic [TMR_W-1:0] TMR_ONE      = TMR_W'(1);

    logic clk_level, clk_fall;
    logic data_level, data_fall_unused;

    ps2_line_sync u_clk_sync (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .line_in (ps2_clk_in),
        .level   (clk_level),
        .fall    (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .line_in (ps2_data_in),
        .level   (data_level),
        .fall    (data_fall_unused)
    );

    ps2_tx_state_t    state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [3:0]       edge_cnt_q, edge_cnt_d;
    logic [3:0]       edge_next;
    logic [7:0]       data_q, data_d;
    logic             parity_q, parity_d;
    logic             nack_q, nack_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    assign edge_next = edge_cnt_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        edge_cnt_d = edge_cnt_q;
        data_d     = data_q;
        parity_d   = parity_q;
        nack_d     = nack_q;
        clk_oe_d   = clk_oe_q;
        data_oe_d  = data_oe_q;
        done_d     = 1'b0;
        error_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid && tx_ready) begin
                    data_d   = tx_data;
                    parity_d = odd_parity(tx_data);
                    nack_d   = 1'b0;
                    tmr_d    = INHIBIT_LOAD;
                    clk_oe_d = 1'b1;
                    state_d  = ST_INHIBIT;
                end
            end

            ST_INHIBIT: begin
                if (tmr_q == '0) begin
                    data_oe_d = 1'b1;
                    state_d   = ST_RELEASE;
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end

            ST_RELEASE: begin
                clk_oe_d   = 1'b0;
                data_oe_d  = 1'b1;
                edge_cnt_d = 4'd0;
                tmr_d      = TIMEOUT_LOAD;
                state_d    = ST_SHIFT;
            end

            ST_SHIFT: begin
                if (clk_fall) begin
                    tmr_d      = TIMEOUT_LOAD;
                    edge_cnt_d = edge_next;
                    if (edge_next <= 4'd8) begin
                        data_oe_d = ~data_q[edge_cnt_q[2:0]];
                    end else if (edge_next == PS2_EDGE_PARITY) begin
                        data_oe_d = ~parity_q;
                    end else if (edge_next == PS2_EDGE_STOP) begin
                        data_oe_d = 1'b0;
                    end else if (edge_next == PS2_EDGE_ACK) begin
                        data_oe_d = 1'b0;
                        nack_d    = data_level;
                        state_d   = ST_WAIT_IDLE;
                    end
                end else if (tmr_q == '0) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    error_d   = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end

            ST_WAIT_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (clk_level && data_level) begin
                    state_d = ST_IDLE;
                    if (ACK_CHECK && nack_q) begin
                        error_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (clk_fall) begin
                    tmr_d = TIMEOUT_LOAD;
                end else if (tmr_q == '0) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end

            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            edge_cnt_q <= 4'd0;
            data_q     <= 8'd0;
            parity_q   <= 1'b0;
            nack_q     <= 1'b0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            edge_cnt_q <= edge_cnt_d;
            data_q     <= data_d;
            parity_q   <= parity_d;
            nack_q     <= nack_d;
            clk_oe_q   <= clk_oe_d;
            data_oe_q  <= data_oe_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    // Ready is held off during the report pulse so a pending byte starts one cycle later.
    assign tx_ready    = (state_q == ST_IDLE) && !done_q && !error_q;
    assign busy        = !tx_ready;
    assign done        = done_q;
    assign error       = error_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a clocking PS/2 device model and a vector table.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int unsigned INH  = 50;
    localparam int unsigned TMO  = 1000;
    localparam int unsigned HALF = 20;

    logic       sys_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, done, error;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk  = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_line, ps2_data_line;

    assign ps2_clk_line  = dev_clk  & ~ps2_clk_oe;
    assign ps2_data_line = dev_data & ~ps2_data_oe;

    always #5 sys_clk = ~sys_clk;

    ps2_host_tx #(
        .CLK_HZ         (50_000_000),
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .ps2_clk_in  (ps2_clk_line),
        .ps2_data_in (ps2_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    int   cyc = 0;
    int   t_clk_rise = 0, t_data_rise = 0, t_clk_fall = 0;
    int   n_done = 0, n_err = 0;
    logic prev_clk_oe = 1'b0, prev_data_oe = 1'b0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        prev_clk_oe  <= ps2_clk_oe;
        prev_data_oe <= ps2_data_oe;
        if (ps2_clk_oe && !prev_clk_oe) t_clk_rise <= cyc;
        if (!ps2_clk_oe && prev_clk_oe) t_clk_fall <= cyc;
        if (ps2_clk_oe && ps2_data_oe && !prev_data_oe) t_data_rise <= cyc;
        if (done)  n_done <= n_done + 1;
        if (error) n_err  <= n_err + 1;
        if (done || error) check("done_error_exclusive", done && error, 0);
    end

    task automatic send(input logic [7:0] d);
        int k;
        @(negedge sys_clk);
        tx_data  = d;
        tx_valid = 1'b1;
        for (k = 0; k < 5000; k++) begin
            if (tx_ready) break;
            @(negedge sys_clk);
        end
        check("send_accept", tx_ready, 1);
        @(posedge sys_clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        for (int k = 0; k < 3000; k++) begin
            @(negedge sys_clk);
            if (tx_ready) break;
        end
        check(name, tx_ready, 1);
    endtask

    // Device side: samples start on the host clock release, bits on its own rising edges.
    task automatic dev_frame(input int n_pulses, input logic ack,
                             output logic [10:0] bits, output logic ok);
        int k;
        ok   = 1'b1;
        bits = '0;
        k = 0;
        while (!ps2_clk_oe && k < 5000) begin @(negedge sys_clk); k++; end
        if (k >= 5000) begin ok = 1'b0; return; end
        k = 0;
        while (ps2_clk_oe && k < INH + 20) begin @(negedge sys_clk); k++; end
        if (k >= INH + 20) begin ok = 1'b0; return; end
        repeat (5) @(negedge sys_clk);
        bits[0] = ps2_data_line;
        for (int p = 1; p <= n_pulses; p++) begin
            if (p == 11) dev_data = ~ack;
            dev_clk = 1'b0;
            repeat (HALF) @(negedge sys_clk);
            if (p == n_pulses && n_pulses < 11) return;
            if (p <= 10) bits[p] = ps2_data_line;
            dev_clk = 1'b1;
            repeat (HALF) @(negedge sys_clk);
        end
        dev_data = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       ack;
        logic       par;
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input vec_t v);
        int d0, e0;
        logic [10:0] bits;
        logic ok;
        d0 = n_done;
        e0 = n_err;
        fork
            send(v.data);
            dev_frame(11, v.ack, bits, ok);
        join
        wait_ready("vec_ready");
        check("vec_dev_ok", ok, 1);
        check("vec_frame_bits", bits, {1'b1, v.par, v.data, 1'b0});
        check("vec_done_count", n_done - d0, v.exp_done);
        check("vec_error_count", n_err - e0, v.exp_err);
        check("vec_inhibit_len", t_data_rise - t_clk_rise, INH);
        check("vec_release_delay", t_clk_fall - t_data_rise, 1);
        check("vec_oe_idle", {ps2_clk_oe, ps2_data_oe}, 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1);
    end

    initial begin
        logic [10:0] b1, b2, b3;
        logic ok1, ok2, ok3;
        int d0, e0, td1, te;

        vecs[0] = '{PS2_CMD_SET_LEDS, 1'b1, 1'b1, 1, 0};
        vecs[1] = '{PS2_CMD_ENABLE,   1'b1, 1'b0, 1, 0};
`ifdef PS2_TX_ACK_CHECK_EN
        vecs[2] = '{PS2_CMD_RESET,    1'b0, 1'b1, 0, 1};
`else
        vecs[2] = '{PS2_CMD_RESET,    1'b0, 1'b1, 1, 0};
`endif
        vecs[3] = '{8'h00,            1'b1, 1'b1, 1, 0};
        vecs[4] = '{PS2_RSP_ACK,      1'b1, 1'b1, 1, 0};

        repeat (3) @(negedge sys_clk);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Back-to-back: second byte waits behind the first with tx_valid held.
        d0 = n_done;
        e0 = n_err;
        td1 = 0;
        fork
            begin
                @(negedge sys_clk);
                tx_data  = PS2_CMD_SET_LEDS;
                tx_valid = 1'b1;
                for (int k = 0; k < 5000 && !tx_ready; k++) @(negedge sys_clk);
                @(posedge sys_clk);
                #1 tx_data = 8'h02;
                @(negedge sys_clk);
                for (int k = 0; k < 5000 && !tx_ready; k++) @(negedge sys_clk);
                @(posedge sys_clk);
                #1 tx_valid = 1'b0;
            end
            begin
                dev_frame(11, 1'b1, b1, ok1);
                for (int k = 0; k < 100 && !done; k++) @(negedge sys_clk);
                td1 = cyc;
                dev_frame(11, 1'b1, b2, ok2);
            end
        join
        wait_ready("b2b_ready");
        check("b2b_dev_ok", ok1 & ok2, 1);
        check("b2b_frame1", b1, {1'b1, 1'b1, 8'hED, 1'b0});
        check("b2b_frame2", b2, {1'b1, 1'b0, 8'h02, 1'b0});
        check("b2b_accept_gap", t_clk_rise - td1, 2);
        check("b2b_done_count", n_done - d0, 2);
        check("b2b_error_count", n_err - e0, 0);

        // Silent device: watchdog expires after the clock release.
        d0 = n_done;
        e0 = n_err;
        send(PS2_RSP_RESEND);
        te = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge sys_clk);
            if (error) begin te = cyc; break; end
        end
        check("tmo_error_seen", error, 1);
        check("tmo_latency", te - t_clk_fall, TMO);
        check("tmo_oe_released", {ps2_clk_oe, ps2_data_oe}, 0);
        @(negedge sys_clk);
        check("tmo_tx_ready", tx_ready, 1);
        check("tmo_error_count", n_err - e0, 1);
        check("tmo_done_count", n_done - d0, 0);

        // Reset in the middle of a frame, after device edge 5 (bit 4 of 0x45 is 0).
        fork
            send(8'h45);
            dev_frame(5, 1'b1, b3, ok3);
        join
        check("midrst_dev_ok", ok3, 1);
        check("midrst_data_oe_before", ps2_data_oe, 1);
        check("midrst_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_clk_oe", ps2_clk_oe, 0);
        check("midrst_data_oe", ps2_data_oe, 0);
        check("midrst_tx_ready", tx_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_done_error", {done, error}, 0);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        run_vec(vecs[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the FPGA to the keyboard over the same PS2_KEYBOARD_CLK/PS2_KEYBOARD_DAT pins the keyboard receiver listens on. It drives both lines as open-drain through output-enables, follows the PS/2 request-to-send sequence, shifts the frame out on device-generated clock edges and reports ack, nack or timeout. It sits beside Keyb_Driver in the top level; `busy` tells the receiver to ignore bus activity while a transmission is in progress.

## Interface
- CLK_HZ, 50_000_000, sys_clk frequency.
- INHIBIT_CYCLES, 5000, clock-inhibit hold before the start bit (100 µs at 50 MHz).
- TIMEOUT_CYCLES, 750_000, maximum gap between device clock falling edges (15 ms).
- sys_clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tx_data  in  8  command byte.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high in IDLE only; byte accepted on rising edge with tx_valid&&tx_ready.
- busy  out  1  high from acceptance until return to IDLE.
- done  out  1  one-cycle pulse: frame sent and acknowledged.
- error  out  1  one-cycle pulse: nack or timeout.
- ps2_clk_in  in  1  raw PS/2 clock pin level.
- ps2_data_in  in  1  raw PS/2 data pin level.
- ps2_clk_oe  out  1  1 = drive clock pin low, 0 = release.
- ps2_data_oe  out  1  1 = drive data pin low, 0 = release.

## Operation
- Inputs pass through a 2-FF synchronizer; falling edge = previous synced level 1, current 0.
- Parity is odd: `~^tx_data`, latched with the byte.
- States:
  - IDLE: both oe 0, tx_ready 1. On accept, latch data and parity, then go to INHIBIT.
  - INHIBIT: clk_oe 1, counting INHIBIT_CYCLES. On terminal count, set data_oe 1 (start bit) and go to RELEASE.
  - RELEASE: clk_oe 0, data_oe 1. Edge counter cleared; go to SHIFT.
  - SHIFT: on each falling edge n, counting 1..11:
    - n = 1..8: data_oe = ~data[n-1] (LSB first).
    - n = 9: data_oe = ~parity.
    - n = 10: data_oe = 0 (stop bit, line released).
    - n = 11: sample synced data. 0 = ack, 1 = nack. Go to WAIT_IDLE.
  - WAIT_IDLE: both oe 0. When both synced lines are high, pulse done (ack) or error (nack), then go to IDLE.
- Watchdog runs in RELEASE, SHIFT and WAIT_IDLE:
  - Cleared on every falling edge and on entering RELEASE.
  - At TIMEOUT_CYCLES: both oe 0, error pulse, go to IDLE.
- tx_valid while busy is ignored; the byte stays pending until tx_ready.
- Reset (asynchronous, also mid-frame): state IDLE, counters 0, clk_oe 0, data_oe 0, busy 0, done 0, error 0, tx_ready 1.

## Timing
- Accept at edge T: clk_oe 1 and busy 1 from T+1.
- data_oe rises exactly INHIBIT_CYCLES cycles after clk_oe rises; clk_oe falls one cycle later.
- data_oe updates 3 sys_clk cycles after a physical PS/2 clock falling edge: 2 sync stages plus 1 register. This is well inside the ≥30 µs low phase.
- done/error are single-cycle pulses and never both high. tx_ready rises the cycle after the pulse.
- Minimum frame: INHIBIT_CYCLES + 11 device clocks + idle detect.

## Configuration
- PS2_TX_ACK_CHECK_EN defined: edge 11 ack sampled; data high gives error.
- Undefined: edge-11 data value ignored, always done (timeout still gives error).

## Structure
- Package ps2_pkg holds:
  - State enum ps2_tx_state_t.
  - Command constants: PS2_CMD_SET_LEDS 8'hED, PS2_CMD_ENABLE 8'hF4, PS2_CMD_RESET 8'hFF, PS2_RSP_ACK 8'hFA, PS2_RSP_RESEND 8'hFE.
- Sub-module ps2_line_sync: 2-FF synchronizer plus falling-edge detect for one line. Instantiated twice here; reusable by the receiver.

## Test plan
1. Reset: rst_n low, then high -> both oe 0, tx_ready 1, busy/done/error 0.
2. INHIBIT_CYCLES=50, send 0xED with a device model that acks:
   - clk_oe high 50 cycles.
   - Device samples on rising edges: start 0, data 1,0,1,1,0,1,1,1, parity 1, stop 1.
   - One done pulse, error 0.
3. Send 0x02 immediately after 0xED with tx_valid held high -> 0x02 accepted only after done; parity bit 0.
4. Device returns data high on edge 11:
   - With PS2_TX_ACK_CHECK_EN: error pulse, no done.
   - Without it: done pulse.
5. TIMEOUT_CYCLES=1000, device never clocks -> error exactly 1000 cycles after clk_oe release; both oe 0; tx_ready 1.
6. Assert rst_n low after edge 5 of a frame -> clk_oe/data_oe 0 with no sys_clk edge; IDLE after release; the next byte is sent correctly.
